// File: rtl/valrdy_stream_sink.sv
// valrdy_stream_sink
//    Consumer end of a val/rdy message stream. Drains messages from a queue's
//    dequeue side, checks each one against an incrementing expected pattern,
//    counts accepted messages and mismatches, and reports completion once a
//    programmed number of transfers has been accepted.
//
// Ports
//    clk            clock, all state updates on the rising edge
//    reset          synchronous active-high reset (aborts any run)
//    start          one-cycle pulse arming a new run (honoured in IDLE/DONE)
//    num_msgs       number of messages in the run, sampled with start
//    init_msg       expected value of the first message, sampled with start
//    msg_val        upstream message valid
//    msg_rdy        sink ready (registered, never depends on msg_val)
//    msg            upstream message payload
//    busy           high while a run is in progress
//    done           high once the programmed number of messages was accepted
//    recv_count     messages accepted in the current or last run
//    err_count      mismatching messages in the current or last run, saturating
//    first_err_msg  payload of the first mismatching message of the run, else 0
//
// Build option
//    VALRDY_STREAM_SINK_RAND_STALL_EN : when defined, an 8-bit Fibonacci LFSR
//    (x^8+x^6+x^5+x^4+1, seeded with p_lfsr_seed) withholds msg_rdy on the
//    RUN cycles where lfsr[1:0] == 2'b00. When undefined, msg_rdy is high
//    throughout RUN.

module valrdy_stream_sink #(
   parameter int          p_msg_nbits   = 32,
   parameter int          p_count_nbits = 16,
   parameter logic [7:0]  p_lfsr_seed   = 8'hA5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [p_count_nbits-1:0]  num_msgs,
   input  logic [p_msg_nbits-1:0]    init_msg,
   input  logic                      msg_val,
   output logic                      msg_rdy,
   input  logic [p_msg_nbits-1:0]    msg,
   output logic                      busy,
   output logic                      done,
   output logic [p_count_nbits-1:0]  recv_count,
   output logic [p_count_nbits-1:0]  err_count,
   output logic [p_msg_nbits-1:0]    first_err_msg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [p_count_nbits-1:0] cnt_zero = {p_count_nbits{1'b0}};
   localparam logic [p_count_nbits-1:0] cnt_one  = p_count_nbits'(1'b1);
   localparam logic [p_count_nbits-1:0] cnt_max  = {p_count_nbits{1'b1}};
   localparam logic [p_msg_nbits-1:0]   msg_zero = {p_msg_nbits{1'b0}};
   localparam logic [p_msg_nbits-1:0]   msg_one  = p_msg_nbits'(1'b1);

   state_t                     state_r,      state_n;
   logic [p_count_nbits-1:0]   target_r,     target_n;
   logic [p_msg_nbits-1:0]     expected_r,   expected_n;
   logic [p_count_nbits-1:0]   recv_count_r, recv_count_n;
   logic [p_count_nbits-1:0]   err_count_r,  err_count_n;
   logic [p_msg_nbits-1:0]     first_err_r,  first_err_n;
   logic                       rdy_r,        rdy_n;
   logic                       busy_r;
   logic                       done_r;
   logic                       xfer_s;
   logic [p_count_nbits-1:0]   recv_inc_s;

`ifdef VALRDY_STREAM_SINK_RAND_STALL_EN
   logic [7:0]                 lfsr_r,       lfsr_n;

   // One Fibonacci step: taps at bits 8,6,5,4 of the polynomial, shift left.
   function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
      lfsr_step = {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
   endfunction
`else
   // The seed only matters for the stall build; tie it off here.
   logic [7:0]                 unused_seed_s;
   assign unused_seed_s = p_lfsr_seed;
`endif

   // Outputs come straight from registers.
   assign msg_rdy       = rdy_r;
   assign busy          = busy_r;
   assign done          = done_r;
   assign recv_count    = recv_count_r;
   assign err_count     = err_count_r;
   assign first_err_msg = first_err_r;

   // rdy_r is only ever high in RUN, so this is the complete transfer condition.
   assign xfer_s     = msg_val & rdy_r;
   assign recv_inc_s = recv_count_r + cnt_one;

   // Next-state and datapath logic for the run control FSM.
   always_comb begin
      state_n      = state_r;
      target_n     = target_r;
      expected_n   = expected_r;
      recv_count_n = recv_count_r;
      err_count_n  = err_count_r;
      first_err_n  = first_err_r;
`ifdef VALRDY_STREAM_SINK_RAND_STALL_EN
      lfsr_n       = lfsr_r;
`endif

      case (state_r)
         IDLE, DONE: begin
            if (start) begin
               target_n     = num_msgs;
               expected_n   = init_msg;
               recv_count_n = cnt_zero;
               err_count_n  = cnt_zero;
               first_err_n  = msg_zero;
`ifdef VALRDY_STREAM_SINK_RAND_STALL_EN
               lfsr_n       = p_lfsr_seed;
`endif
               if (num_msgs == cnt_zero) begin
                  state_n = DONE;
               end else begin
                  state_n = RUN;
               end
            end else begin
               state_n = state_r;
            end
         end

         RUN: begin
`ifdef VALRDY_STREAM_SINK_RAND_STALL_EN
            lfsr_n = lfsr_step(lfsr_r);
`endif
            if (xfer_s) begin
               recv_count_n = recv_inc_s;
               expected_n   = expected_r + msg_one;
               if (msg != expected_r) begin
                  // err_count_r is zero exactly until the first mismatch.
                  if (err_count_r == cnt_zero) begin
                     first_err_n = msg;
                  end else begin
                     first_err_n = first_err_r;
                  end
                  if (err_count_r != cnt_max) begin
                     err_count_n = err_count_r + cnt_one;
                  end else begin
                     err_count_n = err_count_r;
                  end
               end else begin
                  err_count_n = err_count_r;
               end
               // Final transfer is taken on this edge; leave RUN together with it.
               if (recv_inc_s == target_r) begin
                  state_n = DONE;
               end else begin
                  state_n = RUN;
               end
            end else begin
               state_n = RUN;
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase

      // Ready is precomputed for the next cycle so it can be a plain register.
`ifdef VALRDY_STREAM_SINK_RAND_STALL_EN
      rdy_n = (state_n == RUN) && (lfsr_n[1:0] != 2'b00);
`else
      rdy_n = (state_n == RUN);
`endif
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         target_r     <= cnt_zero;
         expected_r   <= msg_zero;
         recv_count_r <= cnt_zero;
         err_count_r  <= cnt_zero;
         first_err_r  <= msg_zero;
         rdy_r        <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
`ifdef VALRDY_STREAM_SINK_RAND_STALL_EN
         lfsr_r       <= p_lfsr_seed;
`endif
      end else begin
         state_r      <= state_n;
         target_r     <= target_n;
         expected_r   <= expected_n;
         recv_count_r <= recv_count_n;
         err_count_r  <= err_count_n;
         first_err_r  <= first_err_n;
         rdy_r        <= rdy_n;
         busy_r       <= (state_n == RUN);
         done_r       <= (state_n == DONE);
`ifdef VALRDY_STREAM_SINK_RAND_STALL_EN
         lfsr_r       <= lfsr_n;
`endif
      end
   end

endmodule

// File: tb/tb_valrdy_stream_sink.sv
// tb_valrdy_stream_sink
//    Directed bench for valrdy_stream_sink with 8-bit messages and counters.
//    A vector table covers reset, normal runs, mismatches, message wrap,
//    zero-length runs, re-arming from DONE and mid-run reset; hand-written
//    sequences cover the all-ones target and the stall build.

module tb_valrdy_stream_sink;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] num_msgs;
   logic [7:0] init_msg;
   logic       msg_val;
   logic       msg_rdy;
   logic [7:0] msg;
   logic       busy;
   logic       done;
   logic [7:0] recv_count;
   logic [7:0] err_count;
   logic [7:0] first_err_msg;

   int total = 0;
   int bad   = 0;

   valrdy_stream_sink #(
      .p_msg_nbits   (8),
      .p_count_nbits (8),
      .p_lfsr_seed   (8'hA5)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .num_msgs      (num_msgs),
      .init_msg      (init_msg),
      .msg_val       (msg_val),
      .msg_rdy       (msg_rdy),
      .msg           (msg),
      .busy          (busy),
      .done          (done),
      .recv_count    (recv_count),
      .err_count     (err_count),
      .first_err_msg (first_err_msg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       st;
      logic [7:0] num;
      logic [7:0] init;
      logic       val;
      logic [7:0] m;
      logic       e_rdy;
      logic       e_busy;
      logic       e_done;
      logic [7:0] e_recv;
      logic [7:0] e_err;
      logic [7:0] e_first;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, input logic st, input logic [7:0] num,
                               input logic [7:0] init, input logic val, input logic [7:0] m,
                               input logic e_rdy, input logic e_busy, input logic e_done,
                               input logic [7:0] e_recv, input logic [7:0] e_err,
                               input logic [7:0] e_first);
      vec_t v;
      v.rst = rst; v.st = st; v.num = num; v.init = init; v.val = val; v.m = m;
      v.e_rdy = e_rdy; v.e_busy = e_busy; v.e_done = e_done;
      v.e_recv = e_recv; v.e_err = e_err; v.e_first = e_first;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic st, input logic [7:0] num,
                        input logic [7:0] init, input logic val, input logic [7:0] m);
      reset = rst; start = st; num_msgs = num; init_msg = init; msg_val = val; msg = m;
   endtask

   function automatic logic [7:0] lfsr_model(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   initial begin
      int sent;
      int cycles;
      logic [7:0] lm;
      logic exp_rdy;

      drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);

`ifndef VALRDY_STREAM_SINK_RAND_STALL_EN
      //              rst   st    num    init   val   msg      rdy   busy  done  recv   err    first
      // reset
      vecs.push_back(mk(1'b1, 1'b0, 8'd0, 8'd0,  1'b0, 8'd0,    1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
      // run of 4 from 10, back to back, then DONE holds
      vecs.push_back(mk(1'b0, 1'b1, 8'd4, 8'd10, 1'b0, 8'd0,    1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0));
      vecs.push_back(mk(1'b0, 1'b0, 8'd0, 8'd0,  1'b1, 8'd10,   1'b1, 1'b1, 1'b0, 8'd1, 8'd0, 8'd0));
      vecs.push_back(mk(1'b0, 1'b0, 8'd0, 8'd0,  1'b1, 8'd11,   1'b1, 1'b1, 1'b0, 8'd2, 8'd0, 8'd0));
      vecs.push_back(mk(1'b0, 1'b0, 8'd0, 8'd0,  1'b1, 8'd12,   1'b1, 1'b1, 1'b0, 8'd3, 8'd0, 8'd0));
      vecs.push_back(mk(1'b0, 1'b0, 8'd0, 8'd0,  1'b1, 8'd13,   1'b0, 1'b0, 1'b1, 8'd4, 8'd0, 8'd0));
      vecs.push_back(mk(1'b0, 1'b0, 8'd0, 8'd0,  1'b1, 8'd14,   1'b0, 1'b0, 1'b1, 8'd4, 8'd0, 8'd0));
      // one mismatch: 5,9,7 against 5,6,7
      vecs.push_back(mk(1'b0, 1'b1, 8'd3, 8'd5,  1'b0, 8'd0,    1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0));
      vecs.push_back(mk(1'b0, 1'b0, 8'd0, 8'd0,  1'b1, 8'd5,    1'b1, 1'b1, 1'b0, 8'd1, 8'd0, 8'd0));
      vecs.push_back(mk(1'b0, 1'b0, 8'd0, 8'd0,  1'b1, 8'd9,    1'b1, 1'b1, 1'b0, 8'd2, 8'd1, 8'd9));
      vecs.push_back(mk(1'b0, 1'b0, 8'd0, 8'd0,  1'b1, 8'd7,    1'b0, 1'b0, 1'b1, 8'd3, 8'd1, 8'd9));
      // every message wrong: first_err_msg keeps the first one
      vecs.push_back(mk(1'b0, 1'b1, 8'd3, 8'd0,  1'b0, 8'd0,    1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0));
      vecs.push_back(mk(1'b0, 1'b0, 8'd0, 8'd0,  1'b1, 8'd5,    1'b1, 1'b1, 1'b0, 8'd1, 8'd1, 8'd5));
      vecs.push_back(mk(1'b0, 1'b0, 8'd0, 8'd0,  1'b1, 8'd6,    1'b1, 1'b1, 1'b0, 8'd2, 8'd2, 8'd5));
      vecs.push_back(mk(1'b0, 1'b0, 8'd0, 8'd0,  1'b1, 8'd7,    1'b0, 1'b0, 1'b1, 8'd3, 8'd3, 8'd5));
      // expected value wraps FE,FF,00
      vecs.push_back(mk(1'b0, 1'b1, 8'd3, 8'hFE, 1'b0, 8'd0,    1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0));
      vecs.push_back(mk(1'b0, 1'b0, 8'd0, 8'd0,  1'b1, 8'hFE,   1'b1, 1'b1, 1'b0, 8'd1, 8'd0, 8'd0));
      vecs.push_back(mk(1'b0, 1'b0, 8'd0, 8'd0,  1'b1, 8'hFF,   1'b1, 1'b1, 1'b0, 8'd2, 8'd0, 8'd0));
      vecs.push_back(mk(1'b0, 1'b0, 8'd0, 8'd0,  1'b1, 8'h00,   1'b0, 1'b0, 1'b1, 8'd3, 8'd0, 8'd0));
      // zero-length run, re-arm from DONE, idle cycle and ignored start in RUN
      vecs.push_back(mk(1'b0, 1'b1, 8'd0, 8'h77, 1'b1, 8'h77,   1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0));
      vecs.push_back(mk(1'b0, 1'b1, 8'd2, 8'h20, 1'b0, 8'd0,    1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0));
      vecs.push_back(mk(1'b0, 1'b0, 8'd0, 8'd0,  1'b0, 8'h55,   1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0));
      vecs.push_back(mk(1'b0, 1'b1, 8'd9, 8'h50, 1'b1, 8'h20,   1'b1, 1'b1, 1'b0, 8'd1, 8'd0, 8'd0));
      vecs.push_back(mk(1'b0, 1'b0, 8'd0, 8'd0,  1'b1, 8'h21,   1'b0, 1'b0, 1'b1, 8'd2, 8'd0, 8'd0));
      // reset after 2 of 5 transfers with start and msg_val also high
      vecs.push_back(mk(1'b0, 1'b1, 8'd5, 8'd0,  1'b0, 8'd0,    1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0));
      vecs.push_back(mk(1'b0, 1'b0, 8'd0, 8'd0,  1'b1, 8'd0,    1'b1, 1'b1, 1'b0, 8'd1, 8'd0, 8'd0));
      vecs.push_back(mk(1'b0, 1'b0, 8'd0, 8'd0,  1'b1, 8'd1,    1'b1, 1'b1, 1'b0, 8'd2, 8'd0, 8'd0));
      vecs.push_back(mk(1'b1, 1'b1, 8'd3, 8'd0,  1'b1, 8'd9,    1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
      vecs.push_back(mk(1'b0, 1'b0, 8'd0, 8'd0,  1'b1, 8'd0,    1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));

      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].st, vecs[i].num, vecs[i].init, vecs[i].val, vecs[i].m);
         @(negedge clk);
         chk($sformatf("v%0d_rdy", i),   msg_rdy,       vecs[i].e_rdy);
         chk($sformatf("v%0d_busy", i),  busy,          vecs[i].e_busy);
         chk($sformatf("v%0d_done", i),  done,          vecs[i].e_done);
         chk($sformatf("v%0d_recv", i),  recv_count,    vecs[i].e_recv);
         chk($sformatf("v%0d_err", i),   err_count,     vecs[i].e_err);
         chk($sformatf("v%0d_first", i), first_err_msg, vecs[i].e_first);
      end

      // All-ones target: 255 transfers from 0x80, wrapping through FF->00, no bubbles.
      drive(1'b0, 1'b1, 8'hFF, 8'h80, 1'b0, 8'h00);
      @(negedge clk);
      sent = 0;
      cycles = 0;
      while (!done && cycles < 600) begin
         exp_rdy = msg_rdy;
         drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'(8'h80 + sent));
         @(negedge clk);
         if (exp_rdy) sent++;
         cycles++;
      end
      chk("max_done",   done,       1'b1);
      chk("max_sent",   sent,       255);
      chk("max_cycles", cycles,     255);
      chk("max_recv",   recv_count, 8'hFF);
      chk("max_err",    err_count,  8'h00);
      chk("max_rdy",    msg_rdy,    1'b0);
`else
      // Reset state, then 64 messages against the LFSR stall reference.
      @(negedge clk);
      @(negedge clk);
      chk("rst_rdy",  msg_rdy,    1'b0);
      chk("rst_busy", busy,       1'b0);
      chk("rst_done", done,       1'b0);
      chk("rst_recv", recv_count, 8'd0);
      drive(1'b0, 1'b1, 8'd64, 8'd0, 1'b0, 8'h00);
      @(negedge clk);
      chk("st_busy", busy, 1'b1);
      lm = 8'hA5;
      sent = 0;
      cycles = 0;
      while (!done && cycles < 400) begin
         exp_rdy = (lm[1:0] != 2'b00);
         chk($sformatf("stall_rdy_c%0d", cycles), msg_rdy, exp_rdy);
         drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'(sent));
         @(negedge clk);
         if (exp_rdy) sent++;
         lm = lfsr_model(lm);
         cycles++;
      end
      chk("stall_done", done,          1'b1);
      chk("stall_sent", sent,          64);
      chk("stall_recv", recv_count,    8'd64);
      chk("stall_err",  err_count,     8'd0);
      chk("stall_fst",  first_err_msg, 8'd0);
      chk("stall_rdy",  msg_rdy,       1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
